// File: rtl/time_counter_if.sv
// Signal bundle between the time-of-day counter and its surroundings.
// Carries the run/set controls and the BCD time outputs. When
// TIME_COUNTER_ALARM_EN is defined the alarm controls and outputs are
// added to the bundle as well.
interface time_counter_if;

   // Controls driven towards the counter
   logic       enb;
   logic       set_mode;
   logic       inc_min;
   logic       inc_hr;

   // Registered time outputs, BCD {tens, units}
   logic [7:0] hh;
   logic [7:0] mm;
   logic [7:0] ss;
   logic       min_tick;

`ifdef TIME_COUNTER_ALARM_EN
   logic       alarm_sel;
   logic       alarm_arm;
   logic [7:0] alarm_hh;
   logic [7:0] alarm_mm;
   logic       alarm;

   modport master (
      output enb, set_mode, inc_min, inc_hr, alarm_sel, alarm_arm,
      input  hh, mm, ss, min_tick, alarm_hh, alarm_mm, alarm
   );

   modport slave (
      input  enb, set_mode, inc_min, inc_hr, alarm_sel, alarm_arm,
      output hh, mm, ss, min_tick, alarm_hh, alarm_mm, alarm
   );
`else
   modport master (
      output enb, set_mode, inc_min, inc_hr,
      input  hh, mm, ss, min_tick
   );

   modport slave (
      input  enb, set_mode, inc_min, inc_hr,
      output hh, mm, ss, min_tick
   );
`endif

endinterface : time_counter_if

// File: rtl/time_counter.sv
// BCD time-of-day counter (hh:mm:ss, 24-hour) advanced by a 1 Hz enable.
// Run mode counts seconds with carries into minutes and hours and emits a
// one-cycle min_tick on every seconds wrap. Set mode freezes counting,
// holds seconds at 00 and lets inc_min / inc_hr step the minutes and hours
// with no carry between them.
// Optional feature: define TIME_COUNTER_ALARM_EN to add an hh:mm alarm
// with its own set path (alarm_sel) and an arm input.
module time_counter #(
   parameter logic [7:0] RST_HH = 8'h00,
   parameter logic [7:0] RST_MM = 8'h00
) (
   input logic           clk,
   input logic           rst_n,
   time_counter_if.slave tc
);

   // BCD +1 modulo 60; bit 8 is the carry out of the 59->00 wrap.
   // Anything at or above 59 wraps, so a corrupt value cannot escape BCD.
   function automatic logic [8:0] bcd_inc60(input logic [7:0] v);
      logic [8:0] r;
      if (v >= 8'h59)
         r = {1'b1, 8'h00};
      else if (v[3:0] >= 4'd9)
         r = {1'b0, v[7:4] + 4'd1, 4'd0};
      else
         r = {1'b0, v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   // BCD +1 modulo 24; hours never carry anywhere.
   function automatic logic [7:0] bcd_inc24(input logic [7:0] v);
      logic [7:0] r;
      if (v >= 8'h23)
         r = 8'h00;
      else if (v[3:0] >= 4'd9)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   logic [7:0] hh_q, mm_q, ss_q;
   logic       tick_q;
   logic [7:0] hh_d, mm_d, ss_d;
   logic       tick_d;

   logic [8:0] sec_inc;
   logic [8:0] min_inc;
   logic [7:0] hr_inc;

   // Set-mode edits aimed at the time registers (not at the alarm)
   logic       edit_alarm;
   logic       set_min;
   logic       set_hr;

   assign sec_inc = bcd_inc60(ss_q);
   assign min_inc = bcd_inc60(mm_q);
   assign hr_inc  = bcd_inc24(hh_q);

`ifdef TIME_COUNTER_ALARM_EN
   assign edit_alarm = tc.alarm_sel;
`else
   assign edit_alarm = 1'b0;
`endif

   assign set_min = tc.set_mode & tc.inc_min & ~edit_alarm;
   assign set_hr  = tc.set_mode & tc.inc_hr  & ~edit_alarm;

   // Next time value: set-mode edits, or run-mode seconds with carries
   always_comb begin
      hh_d   = hh_q;
      mm_d   = mm_q;
      ss_d   = ss_q;
      tick_d = 1'b0;
      if (tc.set_mode) begin
         ss_d = 8'h00;
         if (set_min)
            mm_d = min_inc[7:0];
         if (set_hr)
            hh_d = hr_inc;
      end else if (tc.enb) begin
         ss_d = sec_inc[7:0];
         if (sec_inc[8]) begin
            tick_d = 1'b1;
            mm_d   = min_inc[7:0];
            if (min_inc[8])
               hh_d = hr_inc;
         end
      end
   end

   // Time registers; reset drops every pending increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hh_q   <= RST_HH;
         mm_q   <= RST_MM;
         ss_q   <= 8'h00;
         tick_q <= 1'b0;
      end else begin
         hh_q   <= hh_d;
         mm_q   <= mm_d;
         ss_q   <= ss_d;
         tick_q <= tick_d;
      end
   end

   assign tc.hh       = hh_q;
   assign tc.mm       = mm_q;
   assign tc.ss       = ss_q;
   assign tc.min_tick = tick_q;

`ifdef TIME_COUNTER_ALARM_EN
   logic [7:0] ahh_q, amm_q;
   logic       alarm_q;
   logic [7:0] ahh_d, amm_d;
   logic       alarm_d;
   logic [8:0] amin_inc;
   logic [7:0] ahr_inc;
   logic       alarm_match;

   assign amin_inc = bcd_inc60(amm_q);
   assign ahr_inc  = bcd_inc24(ahh_q);

   // Only an exact hh:mm:00 hit while counting can raise the alarm
   assign alarm_match = ~tc.set_mode & tc.alarm_arm &
                        (hh_q == ahh_q) & (mm_q == amm_q) & (ss_q == 8'h00);

   // Alarm time edits (same wrap rules as the clock) and alarm latch
   always_comb begin
      ahh_d   = ahh_q;
      amm_d   = amm_q;
      alarm_d = alarm_q;
      if (tc.set_mode && tc.alarm_sel) begin
         if (tc.inc_min)
            amm_d = amin_inc[7:0];
         if (tc.inc_hr)
            ahh_d = ahr_inc;
      end
      if (!tc.alarm_arm || tc.set_mode)
         alarm_d = 1'b0;
      else if (alarm_match)
         alarm_d = 1'b1;
      else if (mm_d != mm_q)
         alarm_d = 1'b0;
   end

   // Alarm registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ahh_q   <= 8'h00;
         amm_q   <= 8'h00;
         alarm_q <= 1'b0;
      end else begin
         ahh_q   <= ahh_d;
         amm_q   <= amm_d;
         alarm_q <= alarm_d;
      end
   end

   assign tc.alarm_hh = ahh_q;
   assign tc.alarm_mm = amm_q;
   assign tc.alarm    = alarm_q;
`endif

endmodule : time_counter
